// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ADDSUB,
    MUL,
    FIN
  } state_e;
endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the expression controller (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (output start, op, a, b, input busy, done, result, overflow);
  modport slave  (input start, op, a, b, output busy, done, result, overflow);
endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per step, LSB first, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_prod,
  output logic               o_finished
);
  localparam logic [WIDTH-1:0] ITERS = WIDTH'(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_cnt;

  assign o_prod     = r_acc;
  assign o_finished = (r_cnt == ITERS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_cnt    <= '0;
    end else if (i_step && !o_finished) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + WIDTH'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential add/sub/signed-multiply ALU with done pulse and held overflow.
// Define ALU_SEQ_SAT_EN to saturate the result on overflow instead of wrapping.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  state_e             r_state, w_next;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf;

  logic               w_accept, w_load_res;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic               w_mul_fin, w_mul_neg, w_mul_ovf;
  logic [WIDTH-1:0]   w_b_inv, w_cin, w_sum;
  logic               w_as_ovf;
  logic [WIDTH-1:0]   w_fin_raw, w_fin_res;
  logic               w_fin_ovf, w_fin_neg;

  assign w_accept = (r_state == IDLE) && bus.start;

  // Magnitudes are unsigned WIDTH-bit, so the most-negative operand is exact.
  assign w_mag_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mag_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && (op_e'(bus.op) == OP_MUL)),
    .i_step     (r_state == MUL),
    .i_mcand    (w_mag_a),
    .i_mplier   (w_mag_b),
    .o_prod     (w_prod_mag),
    .o_finished (w_mul_fin)
  );

  assign w_mul_neg = r_a[WIDTH-1] ^ r_b[WIDTH-1];
  assign w_prod    = w_mul_neg ? -w_prod_mag : w_prod_mag;
  assign w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));

  // Subtract as a + ~b + 1; one overflow rule then covers both.
  assign w_b_inv  = (r_op == OP_SUB) ? ~r_b : r_b;
  assign w_cin    = WIDTH'(r_op == OP_SUB);
  assign w_sum    = r_a + w_b_inv + w_cin;
  assign w_as_ovf = (r_a[WIDTH-1] == w_b_inv[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  always_comb begin
    w_fin_raw = '0;
    w_fin_ovf = 1'b0;
    w_fin_neg = 1'b0;
    if (r_state == ADDSUB) begin
      w_fin_raw = w_sum;
      w_fin_ovf = w_as_ovf;
      w_fin_neg = r_a[WIDTH-1];
    end else if (r_state == MUL) begin
      w_fin_raw = w_prod[WIDTH-1:0];
      w_fin_ovf = w_mul_ovf;
      w_fin_neg = w_mul_neg;
    end
  end

`ifdef ALU_SEQ_SAT_EN
  assign w_fin_res = !w_fin_ovf ? w_fin_raw :
                     w_fin_neg  ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_fin_res = w_fin_raw;
`endif

  always_comb begin
    w_next     = r_state;
    w_load_res = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        case (op_e'(bus.op))
          OP_ADD, OP_SUB: w_next = ADDSUB;
          OP_MUL:         w_next = MUL;
          default: begin
            w_next     = FIN;
            w_load_res = 1'b1;
          end
        endcase
      end
      ADDSUB: begin
        w_next     = FIN;
        w_load_res = 1'b1;
      end
      MUL: if (w_mul_fin) begin
        w_next     = FIN;
        w_load_res = 1'b1;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= op_e'(bus.op);
        r_a  <= bus.a;
        r_b  <= bus.b;
      end
      if (w_load_res) begin
        r_result <= w_fin_res;
        r_ovf    <= w_fin_ovf;
      end
    end
  end

  assign bus.busy     = (r_state == ADDSUB) || (r_state == MUL);
  assign bus.done     = (r_state == FIN);
  assign bus.result   = r_result;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed checks of alu_seq (WIDTH=16) against an integer-arithmetic model.
module tb_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // True mathematical result, then wrap or saturate.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic ov);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0:    t = sa + sb;
      2'd1:    t = sa - sb;
      2'd2:    t = sa * sb;
      default: t = 0;
    endcase
    ov = (t > 32767) || (t < -32768);
    r  = t[15:0];
`ifdef ALU_SEQ_SAT_EN
    if (ov) r = (t < 0) ? 16'h8000 : 16'h7fff;
`endif
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      2'd0, 2'd1: return 1;
      2'd2:       return 17;
      default:    return 0;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [15:0] er;
    logic        eo;
    int          cnt;
    int          bad_busy;
    model(op, a, b, er, eo);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    cnt = 0; bad_busy = 0;
    while (!bus.done && cnt < 100) begin
      if (!bus.busy) bad_busy++;
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".lat"}, cnt, exp_lat(op));
    chk({tag, ".busy"}, bad_busy, 0);
    chk({tag, ".res"}, bus.result, er);
    chk({tag, ".ovf"}, bus.overflow, eo);
    chk({tag, ".busy_at_done"}, bus.busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    logic [15:0] er;
    logic        eo;
    int          cnt;
    int          extra;

    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.res", bus.result, 0);
    chk("rst.ovf", bus.overflow, 0);
    @(negedge clk); rst = 1'b0;

    run_op(2'd0, 16'd100, 16'd200, "add_100_200");
    run_op(2'd0, 16'd32767, 16'd1, "add_ovf");
    run_op(2'd1, 16'h8000, 16'd1, "sub_ovf");
    run_op(2'd2, -16'sd5, 16'd7, "mul_m5_7");
    run_op(2'd2, 16'h8000, 16'hffff, "mul_min_m1");
    run_op(2'd2, 16'h8000, 16'd1, "mul_min_1");
    run_op(2'd2, 16'd300, 16'd300, "mul_300_300");
    run_op(2'd3, 16'd5, 16'd9, "rsvd");

    // Start pulse during a multiply must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = -16'sd5; bus.b = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; cnt++; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 16'd1; bus.b = 16'd2;
    @(posedge clk); #1; cnt++;
    bus.start = 1'b0;
    while (!bus.done && cnt < 100) begin @(posedge clk); #1; cnt++; end
    chk("ign_busy.lat", cnt, 17);
    chk("ign_busy.res", bus.result, 16'hffdd);
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.done || bus.busy) extra++; end
    chk("ign_busy.no_extra", extra, 0);

    // Start held through FIN is ignored there, accepted in first IDLE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 16'd100; bus.b = 16'd200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("fin.done", bus.done, 1);
    chk("fin.res", bus.result, 16'd300);
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 16'd10; bus.b = 16'd3;
    @(posedge clk); #1;
    chk("fin.ignored_busy", bus.busy, 0);
    chk("fin.ignored_done", bus.done, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("fin.accept_idle", bus.busy, 1);
    @(posedge clk); #1;
    chk("fin.next_done", bus.done, 1);
    chk("fin.next_res", bus.result, 16'd7);
    @(posedge clk); #1;

    // Reset during iteration 8 of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 16'd1234; bus.b = 16'd567;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1; rst = 1'b1; #1;
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);
    chk("abort.res", bus.result, 0);
    chk("abort.ovf", bus.overflow, 0);
    @(negedge clk); rst = 1'b0;
    extra = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.done) extra++; end
    chk("abort.no_done", extra, 0);
    run_op(2'd0, 16'd1, 16'd1, "post_abort_add");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [15:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = 16'h8000;
        1: ra = 16'h7fff;
        2: ra = 16'($urandom_range(0, 300)) - 16'd150;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rb = 16'hffff;
        1: rb = 16'h8000;
        2: rb = 16'($urandom_range(0, 300)) - 16'd150;
        default: rb = 16'($urandom);
      endcase
      run_op(rop, ra, rb, $sformatf("rnd%0d", i));
    end

    model(2'd0, 16'd1, 16'd1, er, eo);
    run_op(2'd0, 16'd1, 16'd1, "final_add");
    chk("final_model", bus.result, er);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
